pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is split into CHUNK-bit ripple segments, with one register stage per segment. This gives one operation per cycle at a clock rate set by CHUNK rather than WIDTH. A valid/ready handshake on both sides lets the block sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 16: operand and result width in bits.
- CHUNK, 4: bits resolved per pipeline stage. WIDTH must be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in. Used only when sub=0.
- sub  input  1  0: a+b+cin. 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. When sub=1, 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Accept:** a beat is accepted on a rising edge where in_valid && in_ready.
- **Stage k (0..STAGES-1):**
  - adds chunk k of A and B' plus the carry registered by stage k-1;
  - stage 0 takes its carry from cin, or from 1 when sub=1;
  - B' = b, or ~b when sub=1.
- **Operand skew:** unconsumed upper chunks of A and B' travel with the beat in delay registers. Already-computed lower sum chunks also travel forward, so the full result is aligned at the last stage.
- **Valid bits:** each stage holds a valid bit. Bubbles travel through the pipe and are not compressed.
- **Stall:** stall = out_valid && !out_ready. While stall=1, every stage register, valid bit and output holds. When stall=0, the whole pipe advances one stage.
- **in_ready:** in_ready = !stall (combinational from out_valid and out_ready).
- **Output registers:** sum, cout and ovf are registered in the last stage. They change only when the pipe advances.
- **ovf:** computed from the carry into bit WIDTH-1 and the carry out of bit WIDTH-1. For sub=1, this is signed overflow of a-b.
- **Reset:** every valid bit, sum, cout and ovf go to 0 asynchronously. Data registers may also clear.
- **Degenerate case:** CHUNK=WIDTH gives a single-stage registered adder with the same handshake.

## Timing
- **Latency:** a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when there is no stall, i.e. STAGES register stages.
- **Throughput:** one beat per cycle while out_ready=1.
- **Stall length:** a beat held at the output by out_ready=0 stays there, unchanged, until the edge where out_ready=1. It is then retired, and the next beat, if present, appears in the same edge.
- **Ordering:** results leave in acceptance order. There are no drops and no duplicates.
- **Simultaneous out_valid && out_ready && in_valid:** accept and retire both occur in the same edge.
- **Reset asserted mid-operation:** all in-flight beats are discarded and out_valid=0 immediately, without waiting for a clock edge.
- **After reset release:** in_ready=1 on the first cycle. The first result appears STAGES edges after the first accept. No stale data ever appears with out_valid=1.

## Test plan
Defaults: WIDTH=16, CHUNK=4, STAGES=4.

1. a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 edges: sum=0x0000, cout=1, ovf=0. This exercises carry ripple across all four stages.
2. a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
3. sub=1 with cin=1 (cin must be ignored):
   - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0;
   - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1;
   - a=0x1234, b=0x1234 -> sum=0x0000, cout=1, ovf=0.
4. Streaming with backpressure:
   - stimulus: 10 back-to-back random beats, with out_ready=0 for 3 cycles once the first result appears;
   - required: in_ready=0 exactly during the stall cycles, outputs held, all 10 results correct and in order, no gaps after the stall ends.
5. Reset mid-operation:
   - stimulus: accept 3 beats, assert rst for 1 cycle before any result appears;
   - required: out_valid=0 immediately and sum/cout/ovf=0; no result appears for the discarded beats; the next beat after release completes in 4 edges.
6. Parameter sweep at WIDTH=8, CHUNK=8 and at WIDTH=32, CHUNK=8:
   - random operands, both modes, random out_ready;
   - required: results match the reference model, with latency 1 and 4 respectively.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder
//
// Two's-complement adder/subtractor whose WIDTH-bit carry chain is cut into
// CHUNK-bit ripple segments, one register stage per segment
// (STAGES = WIDTH/CHUNK). Stage k adds operand chunk k plus the carry
// registered by stage k-1. Operand bits that are not yet consumed travel
// forward with the beat. Sum chunks that are already resolved also travel
// forward, so the whole result lines up in the last stage. WIDTH must be a
// multiple of CHUNK. CHUNK == WIDTH gives a single registered adder.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears every stage)
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (= !stall)
//   a, b       operands (WIDTH bits)
//   cin        carry in, used only when sub = 0
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  consumer takes the result this cycle
//   sum        result (WIDTH bits, registered)
//   cout       carry out of the MSB (for sub = 1, 1 means no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)

module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic stall;
  logic advance;

  // A result held at the output freezes the whole pipe, bubbles included.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unresolved when a beat enters this stage.
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]           a_in;
    logic [REM-1:0]           b_in;
    logic                     c_in;
    logic                     v_in;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   s_nxt;
    logic [(k+1)*CHUNK-1:0]   s_q;
    logic                     c_q;
    logic                     v_q;

    if (k == 0) begin : g_src
      // Subtraction inverts B and forces the stage-0 carry to 1.
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign s_nxt = part[CHUNK-1:0];
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_ops.a_q;
      assign b_in  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_nxt = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    // One CHUNK-bit ripple segment; the top bit is the carry to the next stage.
    assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in};

    // Stage valid, carry and resolved sum bits; all hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= part[CHUNK];
        s_q <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      // Upper operand chunks that later stages still have to add.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[REM-1:CHUNK];
          b_q <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic carry_into_msb;

      // Sum bit = a ^ b' ^ carry-in, so the carry into the MSB can be
      // recovered from the MSB sum bit without a separate tap in the chain.
      assign carry_into_msb = s_nxt[WIDTH-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];

      // Signed overflow flag, registered with the rest of the result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= carry_into_msb ^ part[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table on the
// 16/4 configuration, streaming with backpressure, reset corner cases, and
// random sweeps on 8/8 and 32/8 configurations against a reference model.

module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16/4 instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  // 8/8 instance
  logic        in_valid_8, in_ready_8, cin_8, sub_8, out_valid_8, out_ready_8, cout_8, ovf_8;
  logic [7:0]  a_8, b_8, sum_8;
  // 32/8 instance
  logic        in_valid_32, in_ready_32, cin_32, sub_32, out_valid_32, out_ready_32, cout_32, ovf_32;
  logic [31:0] a_32, b_32, sum_32;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .a(a_8), .b(b_8),
    .cin(cin_8), .sub(sub_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .sum(sum_8), .cout(cout_8), .ovf(ovf_8));

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut_32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_32), .in_ready(in_ready_32), .a(a_32), .b(b_32),
    .cin(cin_32), .sub(sub_32), .out_valid(out_valid_32), .out_ready(out_ready_32),
    .sum(sum_32), .cout(cout_32), .ovf(ovf_32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: returns {sum, cout, ovf} packed as (sum << 2) | (cout << 1) | ovf.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb, input int w);
    logic [63:0] mask, lmask, yp, full, low, c0;
    mask  = (64'd1 << w) - 64'd1;
    lmask = (64'd1 << (w - 1)) - 64'd1;
    yp    = sb ? (~y & mask) : (y & mask);
    c0    = {63'd0, (sb | ci)};
    full  = (x & mask) + yp + c0;
    low   = (x & lmask) + (yp & lmask) + c0;
    return ((full & mask) << 2) | {62'd0, full[w], low[w-1] ^ full[w]};
  endfunction

  // Single beat through the 16/4 instance; checks latency (edges incl. accept) and result.
  task automatic run_beat(input vec_t v, input string nm);
    int edges;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check({nm, " latency"}, 64'(edges), 64'd4);
    check({nm, " sum"},     64'(sum),   64'(v.sum));
    check({nm, " cout"},    64'(cout),  64'(v.cout));
    check({nm, " ovf"},     64'(ovf),   64'(v.ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sa [10];
    logic [15:0] sbv [10];
    logic        sc [10];
    logic        ss [10];
    logic [63:0] q8 [$];
    logic [63:0] q32 [$];
    int          sent, got, stall_left, not_ready, stale, lat8, lat32;
    bit          started, ovs, exp_ir, ov8, ov32;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; sub_8 = 1'b0; out_ready_8 = 1'b1;
    in_valid_32 = 1'b0; a_32 = '0; b_32 = '0; cin_32 = 1'b0; sub_32 = 1'b0; out_ready_32 = 1'b1;

    // Reset state
    repeat (2) tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum",       64'(sum),       64'd0);
    check("reset cout",      64'(cout),      64'd0);
    check("reset ovf",       64'(ovf),       64'd0);
    rst = 1'b0;
    check("release in_ready", 64'(in_ready), 64'd1);
    tick();

    // Directed vector table
    for (int i = 0; i < 9; i++) run_beat(vecs[i], $sformatf("vec%0d", i));
    repeat (2) tick();

    // Streaming: 10 back-to-back beats, 3-cycle stall once the first result shows
    for (int i = 0; i < 10; i++) begin
      sa[i] = 16'($urandom); sbv[i] = 16'($urandom);
      sc[i] = 1'($urandom);  ss[i]  = 1'($urandom);
    end
    sent = 0; got = 0; stall_left = 0; not_ready = 0; started = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      ovs = out_valid;
      if (ovs && !started) begin
        started = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < 10) begin
        a = sa[sent]; b = sbv[sent]; cin = sc[sent]; sub = ss[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ir = !(ovs && !out_ready);
      check("stream in_ready", 64'(in_ready), 64'(exp_ir));
      if (!exp_ir) not_ready++;
      if (started) check("stream no gap", 64'(out_valid), 64'd1);
      if (ovs) begin
        check($sformatf("stream result%0d", got), {49'd0, sum, cout, ovf},
              model(64'(sa[got]), 64'(sbv[got]), sc[got], ss[got], 16));
        if (out_ready) got++;
      end
      if (in_valid && exp_ir) sent++;
      tick();
    end
    check("stream count", 64'(got), 64'd10);
    check("stream stall cycles", 64'(not_ready), 64'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Reset with 3 beats in flight, before any result
    for (int i = 0; i < 3; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst sum",       64'(sum),       64'd0);
    tick();
    rst = 1'b0;
    check("midrst in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("midrst stale results", 64'(stale), 64'd0);
    run_beat(vecs[4], "post-reset");
    repeat (2) tick();

    // Asynchronous reset while a result is held at the output
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    tick();
    check("held out_valid", 64'(out_valid), 64'd1);
    check("held result", {61'd0, sum, cout, ovf}, {61'd0, 16'h8000, 1'b0, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async result", {61'd0, sum, cout, ovf}, 64'd0);
    check("async in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Sweep latency: 8/8 expects 1 edge, 32/8 expects 4 edges
    a_8 = 8'h7F; b_8 = 8'h01; cin_8 = 1'b0; sub_8 = 1'b0; in_valid_8 = 1'b1;
    a_32 = 32'hFFFF_FFFF; b_32 = 32'h0000_0001; cin_32 = 1'b0; sub_32 = 1'b0; in_valid_32 = 1'b1;
    tick();
    in_valid_8 = 1'b0; in_valid_32 = 1'b0;
    lat8 = 0; lat32 = 0;
    for (int e = 1; e < 20; e++) begin
      if (out_valid_8 && lat8 == 0) begin
        lat8 = e;
        check("sweep8 first", {53'd0, sum_8, cout_8, ovf_8}, {53'd0, 8'h80, 1'b0, 1'b1});
      end
      if (out_valid_32 && lat32 == 0) begin
        lat32 = e;
        check("sweep32 first", {29'd0, sum_32, cout_32, ovf_32}, {29'd0, 32'h0, 1'b1, 1'b0});
      end
      if (lat8 != 0 && lat32 != 0) break;
      tick();
    end
    check("sweep8 latency",  64'(lat8),  64'd1);
    check("sweep32 latency", 64'(lat32), 64'd4);
    tick();

    // Random sweep with random out_ready, then drain
    for (int cyc = 0; cyc < 340; cyc++) begin
      ov8  = out_valid_8;
      ov32 = out_valid_32;
      if (cyc < 300) begin
        out_ready_8  = ($urandom_range(0, 3) != 0);
        out_ready_32 = ($urandom_range(0, 3) != 0);
        in_valid_8   = ($urandom_range(0, 4) != 0);
        in_valid_32  = ($urandom_range(0, 4) != 0);
      end else begin
        out_ready_8 = 1'b1; out_ready_32 = 1'b1; in_valid_8 = 1'b0; in_valid_32 = 1'b0;
      end
      a_8 = 8'($urandom);   b_8 = 8'($urandom);   cin_8 = 1'($urandom);  sub_8 = 1'($urandom);
      a_32 = $urandom;      b_32 = $urandom;      cin_32 = 1'($urandom); sub_32 = 1'($urandom);
      #1;
      exp_ir = !(ov8 && !out_ready_8);
      check("sweep8 in_ready", 64'(in_ready_8), 64'(exp_ir));
      if (ov8) begin
        if (q8.size() == 0) check("sweep8 spurious", 64'd1, 64'd0);
        else begin
          check("sweep8 result", {53'd0, sum_8, cout_8, ovf_8}, q8[0]);
          if (out_ready_8) void'(q8.pop_front());
        end
      end
      if (in_valid_8 && exp_ir) q8.push_back(model(64'(a_8), 64'(b_8), cin_8, sub_8, 8));

      exp_ir = !(ov32 && !out_ready_32);
      check("sweep32 in_ready", 64'(in_ready_32), 64'(exp_ir));
      if (ov32) begin
        if (q32.size() == 0) check("sweep32 spurious", 64'd1, 64'd0);
        else begin
          check("sweep32 result", {29'd0, sum_32, cout_32, ovf_32}, q32[0]);
          if (out_ready_32) void'(q32.pop_front());
        end
      end
      if (in_valid_32 && exp_ir) q32.push_back(model(64'(a_32), 64'(b_32), cin_32, sub_32, 32));
      tick();
    end
    check("sweep8 drained",  64'(q8.size()),  64'd0);
    check("sweep32 drained", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
